// File: rtl/mode_counter.sv
`default_nettype none
// ============================================================================
// mode_counter : programmable up/down counter with hold/wrap, load, tick
// Rev 1.0 : initial release
// ============================================================================
module mode_counter #(
  parameter int CounterWIDTH = 4,
  parameter int DEF_MODE     = 0
) (
  input  logic                    counter_CLK,
  input  logic                    counter_RST_ASYN,
  input  logic                    counter_En,
  input  logic                    counter_Mode,
  input  logic                    counter_Dir,
  input  logic [CounterWIDTH-1:0] counter_Term,
  input  logic                    counter_Load,
  input  logic [CounterWIDTH-1:0] counter_Load_Val,
  output logic [CounterWIDTH-1:0] count,
  output logic                    counter_finish,
  output logic                    counter_tick
);

  localparam logic [CounterWIDTH-1:0] c_ZERO = '0;
  localparam logic [CounterWIDTH-1:0] c_ONE  = {{(CounterWIDTH-1){1'b0}}, 1'b1};
  localparam logic                    c_RST_MODE = (DEF_MODE != 0);

  logic [CounterWIDTH-1:0] r_count;
  logic                    r_tick;
  logic                    r_mode;

  logic [CounterWIDTH-1:0] w_start;
  logic [CounterWIDTH-1:0] w_terminal;
  logic [CounterWIDTH-1:0] w_next;
  logic [CounterWIDTH-1:0] w_load_clamped;
  logic                    w_at_term;
  logic                    w_over_term;

  // Up counts 0 -> Term, down counts Term -> 0.
  assign w_start        = counter_Dir ? counter_Term : c_ZERO;
  assign w_terminal     = counter_Dir ? c_ZERO : counter_Term;
  assign w_at_term      = (r_count == w_terminal);
  assign w_over_term    = !counter_Dir && (r_count > counter_Term);
  assign w_next         = counter_Dir ? (r_count - c_ONE) : (r_count + c_ONE);
  assign w_load_clamped = (counter_Load_Val > counter_Term) ? counter_Term : counter_Load_Val;

  always_ff @(posedge counter_CLK or negedge counter_RST_ASYN) begin
    if (!counter_RST_ASYN) begin
      r_count <= c_ZERO;
      r_tick  <= 1'b0;
      r_mode  <= c_RST_MODE;
    end else begin
      r_mode <= counter_Mode;
      if (counter_Load) begin
        r_count <= w_load_clamped;
        r_tick  <= 1'b0;
      end else if (!counter_En) begin
        r_count <= w_start;
        r_tick  <= 1'b0;
      end else if (w_over_term) begin
        // Term was lowered below the running count: snap to it.
        r_count <= counter_Term;
        r_tick  <= 1'b1;
      end else if (!w_at_term) begin
        r_count <= w_next;
        r_tick  <= (w_next == w_terminal);
      end else if (!r_mode) begin
        r_tick  <= 1'b0;
      end else begin
        r_count <= w_start;
        r_tick  <= (w_start == w_terminal);
      end
    end
  end

  assign count          = r_count;
  assign counter_tick   = r_tick;
  assign counter_finish = w_at_term;

endmodule
`default_nettype wire

// File: tb/tb_mode_counter.sv
`default_nettype none
// ============================================================================
// tb_mode_counter : directed self-checking bench for mode_counter
// Rev 1.0 : initial release
// ============================================================================
module tb_mode_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, mode, dir, load;
  logic [3:0] term, load_val;
  logic [3:0] count;
  logic       finish, tick;

  int n_checks = 0;
  int n_pass   = 0;

  mode_counter #(.CounterWIDTH(4), .DEF_MODE(0)) u_dut (
    .counter_CLK      (clk),
    .counter_RST_ASYN (rst_n),
    .counter_En       (en),
    .counter_Mode     (mode),
    .counter_Dir      (dir),
    .counter_Term     (term),
    .counter_Load     (load),
    .counter_Load_Val (load_val),
    .count            (count),
    .counter_finish   (finish),
    .counter_tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input int c, input int t, input int f);
    chk({tag, ".count"},  int'(count),  c);
    chk({tag, ".tick"},   int'(tick),   t);
    chk({tag, ".finish"}, int'(finish), f);
  endtask

  initial begin
    int e;
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; dir = 1'b0; load = 1'b0;
    term = 4'd5; load_val = 4'd0;
    #2;
    chk3("reset", 0, 0, 0);
    #10;
    rst_n = 1'b1;

    // Up, hold, Term=5
    for (int i = 1; i <= 7; i++) begin
      step();
      e = (i < 5) ? i : 5;
      chk3($sformatf("up_hold%0d", i), e, (i == 5) ? 1 : 0, (i >= 5) ? 1 : 0);
    end

    // Up, wrap, Term=5
    mode = 1'b1; en = 1'b0;
    step();
    chk("wrap_clr", int'(count), 0);
    en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      e = i % 6;
      chk3($sformatf("up_wrap%0d", i), e, (e == 5) ? 1 : 0, (e == 5) ? 1 : 0);
    end

    // Down, wrap, Term=3
    dir = 1'b1; term = 4'd3; en = 1'b0;
    step();
    chk3("dn_clr", 3, 0, 0);
    en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      e = 3 - (i % 4);
      chk3($sformatf("dn_wrap%0d", i), e, (e == 0) ? 1 : 0, (e == 0) ? 1 : 0);
    end

    // Load clamp then Term lowered below count
    dir = 1'b0; mode = 1'b0; term = 4'd9; en = 1'b0;
    step();
    en = 1'b1;
    repeat (4) step();
    chk("ld_pre", int'(count), 4);
    load = 1'b1; load_val = 4'd12;
    step();
    chk3("ld_clamp", 9, 0, 1);
    load = 1'b0; term = 4'd6;
    step();
    chk3("term_low", 6, 1, 1);
    load = 1'b1; load_val = 4'd2; en = 1'b0;
    step();
    chk3("ld_en0", 2, 0, 0);
    load = 1'b0;
    step();
    chk("en0_clr", int'(count), 0);

    // Term=0 wrap, then switch to hold
    term = 4'd0; mode = 1'b1; en = 1'b0;
    step();
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk3($sformatf("t0_wrap%0d", i), 0, 1, 1);
    end
    mode = 1'b0;
    step();
    chk3("t0_lat", 0, 1, 1);
    step();
    chk3("t0_hold1", 0, 0, 1);
    step();
    chk3("t0_hold2", 0, 0, 1);

    // Async reset mid-count
    term = 4'd10; en = 1'b0;
    step();
    en = 1'b1;
    repeat (7) step();
    chk("ar_pre", int'(count), 7);
    #2 rst_n = 1'b0;
    #1 chk3("ar_now", 0, 0, 0);
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk3($sformatf("ar_resume%0d", i), i, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mode_counter.md
Name: mode_counter

Overview:
- Parametrised successor to the serializer bit counter: programmable terminal value, up/down direction, hold or wrap mode, parallel load, and a registered terminal-count pulse.
- Intended for the serializer bit index, frame-length and baud/oversample dividers in the UART TX/RX paths.
- Replaces the fixed all-ones terminal count with a runtime-programmable one.

Parameters:
- CounterWIDTH, 4, width of count, terminal and load values (min 1).
- DEF_MODE, 0, mode used out of reset: 0 = hold-at-terminal, 1 = wrap. Sampled only for reset state.

Ports:
- counter_CLK  in  1  clock, rising edge.
- counter_RST_ASYN  in  1  asynchronous, active-low reset.
- counter_En  in  1  1 = count; 0 = clear to start value.
- counter_Mode  in  1  0 = hold at terminal, 1 = wrap to start value.
- counter_Dir  in  1  0 = up (start 0, terminal = counter_Term); 1 = down (start counter_Term, terminal 0).
- counter_Term  in  CounterWIDTH  programmable terminal/reload value.
- counter_Load  in  1  synchronous parallel load strobe.
- counter_Load_Val  in  CounterWIDTH  value loaded when counter_Load = 1.
- count  out  CounterWIDTH  registered count.
- counter_finish  out  1  combinational: count equals the terminal value for the current direction.
- counter_tick  out  1  registered one-cycle pulse, high in the cycle count first reaches terminal by stepping.

Behaviour:
- Reset (async, counter_RST_ASYN = 0): count = 0, counter_tick = 0, internal mode register = DEF_MODE. counter_finish follows count, so after reset it is 1 when Dir = 0 and Term = 0, or when Dir = 1.
- Mode register: loads counter_Mode on every clock edge while not in reset. counter_Mode therefore takes effect one cycle after it changes.
- Per-edge priority, highest first:
  1. counter_Load = 1: count = min(counter_Load_Val, counter_Term); tick = 0. Load wins even when En = 0.
  2. counter_En = 0: count = start value (0 if Dir = 0, counter_Term if Dir = 1); tick = 0.
  3. Up, count > counter_Term (Term lowered mid-run): count = counter_Term; tick = 1.
  4. Not at terminal: count = count + 1 (up) or count - 1 (down); tick = 1 iff the new count equals the terminal value.
  5. At terminal, hold mode: count unchanged; tick = 0.
  6. At terminal, wrap mode: count = start value; tick = 1 iff start value == terminal (only possible when Term = 0).
- Arithmetic: modulo 2^CounterWIDTH. Overflow is never reachable because of rules 3 and 4 and the load clamp.
- Latency:
  - count updates one edge after the controlling inputs.
  - counter_finish is combinational on count, Dir and Term.
  - counter_tick aligns with the count value that caused it.
- Wrap-mode period: Term + 1 cycles; one tick per period.
- Dir change mid-run: the next step uses the new direction. No clear is implied, and finish is re-evaluated immediately.
- Term change mid-run:
  - Up: if count > new Term, rule 3 applies.
  - Down: the step continues toward 0.
- Term = 0:
  - Up and down both have terminal 0, and finish = 1 whenever count = 0.
  - Wrap mode: tick = 1 every enabled cycle.
  - Hold mode: no tick.
- En deasserted mid-count: clears on the next edge. Re-asserting En resumes from the start value.
- Async reset mid-operation: outputs clear immediately. The first edge after release follows the normal rules.

Test Plan:
- W = 4, Term = 5, Dir = 0, Mode = 0, En = 1 from reset -> count 0,1,2,3,4,5,5,5. tick high only in the cycle count = 5; finish high from count = 5 onward.
- Same setup, Mode = 1 -> count 0..5,0..5 repeating with period 6; one tick per period, coincident with count = 5.
- Dir = 1, Term = 3, Mode = 1: En low one cycle, then high -> count 3,2,1,0,3,2,1,0; tick coincident with each 0.
- Up count at 4 with Term = 9; assert Load = 1, Load_Val = 12 -> count = 9, tick = 0, finish = 1. Next cycle, Load = 0 and Term lowered to 6 -> count = 6, tick = 1.
- Wrap, Term = 0, En = 1 -> count stays 0, tick = 1 every cycle. Switch Mode to hold -> tick drops one cycle later (mode register latency) and stays 0.
- Mid-count (count = 7, Term = 10), pulse counter_RST_ASYN low between edges -> count = 0 and tick = 0 immediately. After release, counting resumes 1,2,...
